// File: rtl/chrono_counter_pkg.sv
// rtl/chrono_counter_pkg.sv - shared stopwatch constants, FSM encoding and packed time type
package chrono_counter_pkg;

    localparam int DIGIT_W      = 4;
    localparam int NUM_DIGITS   = 8;
    localparam int CENT_MAX     = 9;
    localparam int SEC_TENS_MAX = 5;
    localparam int MIN_TENS_MAX = 5;

    typedef enum logic {
        LIVE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] hr1;
        logic [DIGIT_W-1:0] hr0;
        logic [DIGIT_W-1:0] min1;
        logic [DIGIT_W-1:0] min0;
        logic [DIGIT_W-1:0] sec1;
        logic [DIGIT_W-1:0] sec0;
        logic [DIGIT_W-1:0] cent1;
        logic [DIGIT_W-1:0] cent0;
    } time_t;

    // Digit index 0 is cent0; hour digits count to 9 and rely on the HR_MAX wrap compare.
    function automatic logic [DIGIT_W-1:0] digit_limit(input int idx);
        case (idx)
            3:       return DIGIT_W'(SEC_TENS_MAX);
            5:       return DIGIT_W'(MIN_TENS_MAX);
            default: return DIGIT_W'(CENT_MAX);
        endcase
    endfunction

endpackage

// File: rtl/chrono_counter_if.sv
// rtl/chrono_counter_if.sv - control inputs and display outputs of the time-base
interface chrono_counter_if;
    import chrono_counter_pkg::*;

    logic               tick_cent;
    logic               en;
    logic               clr;
    logic               split;
    logic [DIGIT_W-1:0] o_cent_0;
    logic [DIGIT_W-1:0] o_cent_1;
    logic [DIGIT_W-1:0] o_sec_0;
    logic [DIGIT_W-1:0] o_sec_1;
    logic [DIGIT_W-1:0] o_min_0;
    logic [DIGIT_W-1:0] o_min_1;
    logic [DIGIT_W-1:0] o_hr_0;
    logic [DIGIT_W-1:0] o_hr_1;
    logic               held;
    logic               wrap;

    modport master (
        output tick_cent, en, clr, split,
        input  o_cent_0, o_cent_1, o_sec_0, o_sec_1, o_min_0, o_min_1, o_hr_0, o_hr_1,
        input  held, wrap
    );

    modport slave (
        input  tick_cent, en, clr, split,
        output o_cent_0, o_cent_1, o_sec_0, o_sec_1, o_min_0, o_min_1, o_hr_0, o_hr_1,
        output held, wrap
    );

endinterface

// File: rtl/chrono_counter_bcd_digit.sv
// rtl/chrono_counter_bcd_digit.sv - one BCD digit with parameterised limit and look-ahead carry
module bcd_digit
    import chrono_counter_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] LIMIT = DIGIT_W'(CENT_MAX)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en_in,
    input  logic               i_clr,
    output logic [DIGIT_W-1:0] o_value,
    output logic [DIGIT_W-1:0] o_next,
    output logic               o_carry_out
);

    logic [DIGIT_W-1:0] r_value;
    logic [DIGIT_W-1:0] w_next;

    always_comb begin
        w_next = r_value;
        if (i_clr) begin
            w_next = '0;
        end else if (i_en_in) begin
            w_next = (r_value == LIMIT) ? '0 : r_value + DIGIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else begin
            r_value <= w_next;
        end
    end

    assign o_value     = r_value;
    assign o_next      = w_next;
    assign o_carry_out = i_en_in & (r_value == LIMIT);

endmodule

// File: rtl/chrono_counter.sv
// rtl/chrono_counter.sv - BCD HH:MM:SS.CC time-base with split/lap hold and wrap pulse
module chrono_counter
    import chrono_counter_pkg::*;
#(
    parameter int HR_MAX   = 99,
    parameter int TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    chrono_counter_if.slave   bus
);

    localparam int                 DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIGIT_W-1:0] HR_MAX_1 = DIGIT_W'(HR_MAX / 10);
    localparam logic [DIGIT_W-1:0] HR_MAX_0 = DIGIT_W'(HR_MAX % 10);

    logic [DIV_W-1:0]                     r_div;
    state_t                               r_state;
    state_t                               w_state_next;
    time_t                                r_snap;
    time_t                                r_out;
    time_t                                w_snap_next;
    time_t                                w_out_next;
    time_t                                w_live_next;
    logic                                 r_wrap;
    logic                                 w_step;
    logic                                 w_wrap;
    logic                                 w_capture;
    logic                                 w_unused_carry;
    logic [NUM_DIGITS-1:0]                w_en_in;
    logic [NUM_DIGITS-1:0]                w_carry;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   w_val;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   w_nxt;

    assign w_step         = bus.en & bus.tick_cent & (r_div == DIV_LAST) & ~bus.clr;
    assign w_en_in        = {w_carry[NUM_DIGITS-2:0], w_step};
    // Everything below the hours is at max whenever a step reaches hr0; compare hours against HR_MAX.
    assign w_wrap         = w_en_in[6] & (w_val[7] == HR_MAX_1) & (w_val[6] == HR_MAX_0);
    assign w_unused_carry = w_carry[NUM_DIGITS-1];
    assign w_live_next    = time_t'(w_nxt);

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        bcd_digit #(
            .LIMIT (digit_limit(k))
        ) u_dig (
            .clk         (clk),
            .rst         (rst),
            .i_en_in     (w_en_in[k]),
            .i_clr       (bus.clr | w_wrap),
            .o_value     (w_val[k]),
            .o_next      (w_nxt[k]),
            .o_carry_out (w_carry[k])
        );
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        if (bus.clr) begin
            w_state_next = LIVE;
        end else begin
            case (r_state)
                LIVE: if (bus.split && bus.en) begin
                    w_state_next = HOLD;
                    w_capture    = 1'b1;
                end
                HOLD: if (bus.split) begin
                    w_state_next = LIVE;
                end
                default: w_state_next = LIVE;
            endcase
        end
        w_snap_next = r_snap;
        if (bus.clr) begin
            w_snap_next = '0;
        end else if (w_capture) begin
            w_snap_next = w_live_next;
        end
        w_out_next = (w_state_next == HOLD) ? w_snap_next : w_live_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LIVE;
            r_snap  <= '0;
            r_out   <= '0;
            r_wrap  <= 1'b0;
            r_div   <= '0;
        end else begin
            r_state <= w_state_next;
            r_snap  <= w_snap_next;
            r_out   <= w_out_next;
            r_wrap  <= w_wrap;
            if (bus.clr) begin
                r_div <= '0;
            end else if (bus.en && bus.tick_cent) begin
                r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
            end
        end
    end

    assign bus.o_cent_0 = r_out.cent0;
    assign bus.o_cent_1 = r_out.cent1;
    assign bus.o_sec_0  = r_out.sec0;
    assign bus.o_sec_1  = r_out.sec1;
    assign bus.o_min_0  = r_out.min0;
    assign bus.o_min_1  = r_out.min1;
    assign bus.o_hr_0   = r_out.hr0;
    assign bus.o_hr_1   = r_out.hr1;
    assign bus.held     = (r_state == HOLD);
    assign bus.wrap     = r_wrap;

endmodule

// File: tb/tb_chrono_counter.sv
// tb/tb_chrono_counter.sv - directed bench for chrono_counter with a centisecond-integer reference model
module tb_chrono_counter;

    localparam int HR_MAX  = 2;
    localparam int LIMIT_T = (HR_MAX + 1) * 360000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    chrono_counter_if bus ();

    chrono_counter #(
        .HR_MAX   (HR_MAX),
        .TICK_DIV (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          chk_en   = 1'b0;
    bit          pre_en   = 1'b0;
    int          pre_val  = 0;
    logic [31:0] pre_bcd  = '0;

    int m_live = 0;
    int m_snap = 0;
    bit m_hold = 1'b0;
    bit m_wrap = 1'b0;

    function automatic logic [31:0] to_bcd(input int t);
        int cs, s, m, h;
        cs = t % 100;
        s  = (t / 100) % 60;
        m  = (t / 6000) % 60;
        h  = t / 360000;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    function automatic int adv(input int t, input bit s);
        if (!s) return t;
        return (t + 1 == LIMIT_T) ? 0 : t + 1;
    endfunction

    function automatic logic [31:0] dut_time();
        return {bus.o_hr_1, bus.o_hr_0, bus.o_min_1, bus.o_min_0,
                bus.o_sec_1, bus.o_sec_0, bus.o_cent_1, bus.o_cent_0};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_live <= 0;
            m_snap <= 0;
            m_hold <= 1'b0;
            m_wrap <= 1'b0;
        end else if (pre_en) begin
            m_live <= pre_val;
            m_wrap <= 1'b0;
        end else if (bus.clr) begin
            m_live <= 0;
            m_snap <= 0;
            m_hold <= 1'b0;
            m_wrap <= 1'b0;
        end else begin
            m_live <= adv(m_live, bus.en && bus.tick_cent);
            m_wrap <= bus.en && bus.tick_cent && (m_live == LIMIT_T - 1);
            if (!m_hold && bus.split && bus.en) begin
                m_hold <= 1'b1;
                m_snap <= adv(m_live, bus.en && bus.tick_cent);
            end else if (m_hold && bus.split) begin
                m_hold <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            chk("model_time", dut_time(), to_bcd(m_hold ? m_snap : m_live));
            chk("model_held", 32'(bus.held), 32'(m_hold));
            chk("model_wrap", 32'(bus.wrap), 32'(m_wrap));
        end
    end

    task automatic cyc(input bit t, input bit s, input bit c);
        bus.tick_cent = t;
        bus.split     = s;
        bus.clr       = c;
        @(posedge clk);
        #1;
        bus.tick_cent = 1'b0;
        bus.split     = 1'b0;
        bus.clr       = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task preload(input int t);
        chk_en  = 1'b0;
        bus.en  = 1'b0;
        pre_val = t;
        pre_bcd = to_bcd(t);
        pre_en  = 1'b1;
        force dut.g_dig[0].u_dig.r_value = pre_bcd[3:0];
        force dut.g_dig[1].u_dig.r_value = pre_bcd[7:4];
        force dut.g_dig[2].u_dig.r_value = pre_bcd[11:8];
        force dut.g_dig[3].u_dig.r_value = pre_bcd[15:12];
        force dut.g_dig[4].u_dig.r_value = pre_bcd[19:16];
        force dut.g_dig[5].u_dig.r_value = pre_bcd[23:20];
        force dut.g_dig[6].u_dig.r_value = pre_bcd[27:24];
        force dut.g_dig[7].u_dig.r_value = pre_bcd[31:28];
        @(posedge clk);
        #1;
        release dut.g_dig[0].u_dig.r_value;
        release dut.g_dig[1].u_dig.r_value;
        release dut.g_dig[2].u_dig.r_value;
        release dut.g_dig[3].u_dig.r_value;
        release dut.g_dig[4].u_dig.r_value;
        release dut.g_dig[5].u_dig.r_value;
        release dut.g_dig[6].u_dig.r_value;
        release dut.g_dig[7].u_dig.r_value;
        pre_en = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        bus.en = 1'b1;
    endtask

    initial begin
        bus.tick_cent = 1'b0;
        bus.en        = 1'b0;
        bus.clr       = 1'b0;
        bus.split     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("reset_time", dut_time(), 32'h0000_0000);
        chk("reset_held", 32'(bus.held), 32'd0);
        chk("reset_wrap", 32'(bus.wrap), 32'd0);

        bus.en = 1'b1;
        ticks(150);
        chk("t150", dut_time(), 32'h0000_0150);
        chk("t150_held", 32'(bus.held), 32'd0);

        ticks(5849);
        chk("t5999", dut_time(), 32'h0000_5999);
        ticks(1);
        chk("carry_to_min", dut_time(), 32'h0001_0000);

        cyc(1'b0, 1'b0, 1'b1);
        chk("clr_plain", dut_time(), 32'h0000_0000);
        ticks(320);
        chk("t320", dut_time(), 32'h0000_0320);
        cyc(1'b1, 1'b1, 1'b0);
        chk("split_snap", dut_time(), 32'h0000_0321);
        chk("split_held", 32'(bus.held), 32'd1);
        ticks(100);
        chk("hold_frozen", dut_time(), 32'h0000_0321);
        cyc(1'b0, 1'b1, 1'b0);
        chk("unsplit_live", dut_time(), 32'h0000_0421);
        chk("unsplit_held", 32'(bus.held), 32'd0);

        bus.en = 1'b0;
        ticks(50);
        chk("en_off_frozen", dut_time(), 32'h0000_0421);
        cyc(1'b0, 1'b1, 1'b0);
        chk("split_en_off", 32'(bus.held), 32'd0);
        bus.en = 1'b1;
        ticks(10);
        chk("en_resume", dut_time(), 32'h0000_0431);

        cyc(1'b0, 1'b1, 1'b0);
        chk("hold_again", 32'(bus.held), 32'd1);
        cyc(1'b1, 1'b1, 1'b1);
        chk("clr_all_time", dut_time(), 32'h0000_0000);
        chk("clr_all_held", 32'(bus.held), 32'd0);
        chk("clr_all_wrap", 32'(bus.wrap), 32'd0);
        ticks(1);
        chk("after_clr", dut_time(), 32'h0000_0001);

        preload(719999);
        chk("preload_1h", dut_time(), 32'h0159_5999);
        ticks(1);
        chk("carry_to_hr2", dut_time(), 32'h0200_0000);
        chk("no_wrap_hr2", 32'(bus.wrap), 32'd0);

        preload(1079990);
        ticks(9);
        chk("pre_wrap", dut_time(), 32'h0259_5999);
        chk("pre_wrap_flag", 32'(bus.wrap), 32'd0);
        ticks(1);
        chk("wrap_time", dut_time(), 32'h0000_0000);
        chk("wrap_pulse", 32'(bus.wrap), 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("wrap_one_clk", 32'(bus.wrap), 32'd0);

        ticks(5);
        cyc(1'b1, 1'b1, 1'b0);
        chk("hold_pre_rst", dut_time(), 32'h0000_0006);
        ticks(3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_time", dut_time(), 32'h0000_0000);
        chk("async_rst_held", 32'(bus.held), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ticks(1);
        chk("after_rst", dut_time(), 32'h0000_0001);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
